// File: rtl/register_file_if.sv
// Register-file bus: two read address/data pairs plus one write port.
// The datapath side drives the master modport; the register file takes the slave one.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] Read_Register_1;
  logic [ADDR_WIDTH-1:0] Read_Register_2;
  logic [ADDR_WIDTH-1:0] Write_Register;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] Read_Data_1;
  logic [DATA_WIDTH-1:0] Read_Data_2;

  modport master (
    output Read_Register_1, Read_Register_2, Write_Register, Write_Data, RegWrite,
    input  Read_Data_1, Read_Data_2
  );
  modport slave (
    input  Read_Register_1, Read_Register_2, Write_Register, Write_Data, RegWrite,
    output Read_Data_1, Read_Data_2
  );
endinterface

// File: rtl/register_file.sv
// MIPS register file: two combinational read ports, one synchronous write port, $0 hardwired to 0.
// Define WRITE_BYPASS_EN for write-first reads; otherwise reads are read-first.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave rf
);
  localparam int NUM_RD = 2;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   raddr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdata;

  always_comb begin
    regs_d = regs_q;
    if (rf.RegWrite && rf.Write_Register != '0)
      regs_d[rf.Write_Register] = rf.Write_Data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign raddr[0] = rf.Read_Register_1;
  assign raddr[1] = rf.Read_Register_2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd;
    always_comb begin
      rd = regs_q[raddr[p]];
`ifdef WRITE_BYPASS_EN
      // Bypass is held off during reset so both ports read 0 while rst_n is low.
      if (rst_n && rf.RegWrite && rf.Write_Register == raddr[p])
        rd = rf.Write_Data;
`endif
      if (raddr[p] == '0) rd = '0;
    end
    assign rdata[p] = rd;
  end

  assign rf.Read_Data_1 = rdata[0];
  assign rf.Read_Data_2 = rdata[1];
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values,
// a negedge monitor pops and compares against the DUT read ports.
module tb_register_file;
  logic clk, rst_n;
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .rf(rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[32];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Architectural view: $0 is zero, reset empties the file, bypass only when built in.
  function automatic logic [31:0] ref_rd(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (!rst_n || a == 5'd0) return 32'h0;
`ifdef WRITE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mem[a];
  endfunction

  task automatic push_exp(input string nm);
    exp_t e;
    e.nm = nm;
    e.a1 = rf_if.Read_Register_1;
    e.a2 = rf_if.Read_Register_2;
    e.e1 = ref_rd(e.a1, rf_if.RegWrite, rf_if.Write_Register, rf_if.Write_Data);
    e.e2 = ref_rd(e.a2, rf_if.RegWrite, rf_if.Write_Register, rf_if.Write_Data);
    exp_q.push_back(e);
  endtask

  task automatic edge_update();
    logic we; logic [4:0] wa; logic [31:0] wd; logic rn;
    we = rf_if.RegWrite; wa = rf_if.Write_Register; wd = rf_if.Write_Data; rn = rst_n;
    @(posedge clk);
    if (!rn) foreach (mem[i]) mem[i] = 32'h0;
    else if (we && wa != 5'd0) mem[wa] = wd;
    #1;
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input string nm);
    rf_if.RegWrite = we;
    rf_if.Write_Register = wa;
    rf_if.Write_Data = wd;
    rf_if.Read_Register_1 = r1;
    rf_if.Read_Register_2 = r2;
    push_exp(nm);
    edge_update();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (rf_if.Read_Data_1 !== e.e1) begin
        n_bad++;
        $display("FAIL %s rd1[%0d]: got %h expected %h", e.nm, e.a1, rf_if.Read_Data_1, e.e1);
      end
      n_cmp++;
      if (rf_if.Read_Data_2 !== e.e2) begin
        n_bad++;
        $display("FAIL %s rd2[%0d]: got %h expected %h", e.nm, e.a2, rf_if.Read_Data_2, e.e2);
      end
    end
  end

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    rst_n = 1'b0;
    rf_if.RegWrite = 1'b0;
    rf_if.Write_Register = '0;
    rf_if.Write_Data = '0;
    rf_if.Read_Register_1 = '0;
    rf_if.Read_Register_2 = '0;
    @(posedge clk); #1;

    cyc(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, "reset_state");
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset after R5 is written.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "r5_write");
    cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "r5_readback");
    rf_if.Read_Register_1 = 5'd5;
    rf_if.Read_Register_2 = 5'd5;
    #2 rst_n = 1'b0;
    push_exp("async_reset");
    edge_update();
    for (int k = 0; k < 32; k += 2)
      cyc(1'b0, 5'd0, 32'h0, 5'(k), 5'(k + 1), "reset_all_zero");

    // Write held against reset is lost.
    cyc(1'b1, 5'd7, 32'h77777777, 5'd0, 5'd0, "reset_vs_write");
    rst_n = 1'b1;
    cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd6, "reset_wins");

    cyc(1'b1, 5'd8, 32'h12345678, 5'd9, 5'd1, "basic_write");
    cyc(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, "basic_read");
    cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd8, "untouched_r9");

    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "r0_write");
    cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "r0_protect");

    cyc(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, "r3_setup");
    cyc(1'b0, 5'd3, 32'h22, 5'd3, 5'd0, "we_gate_cycle");
    cyc(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "we_gate_after");

    cyc(1'b1, 5'd4, 32'hA, 5'd0, 5'd0, "r4_setup");
    cyc(1'b1, 5'd4, 32'hB, 5'd3, 5'd4, "hazard_same_cycle");
    cyc(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, "hazard_after");

    for (int k = 1; k < 32; k++)
      cyc(1'b1, 5'(k), k * 32'h01010101, 5'(k), 5'(32 - k), "sweep_write");
    for (int k = 0; k < 32; k++)
      cyc(1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k), "sweep_read");

    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa, r1, r2;
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), wa, $urandom, r1, r2, "random");
    end

    rf_if.RegWrite = 1'b0;
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
